// File: rtl/tgate_mux_arbiter.sv
// Round-robin arbiter that shares one transmission-gate 2:1 mux between two
// requesters. Each gate's n/p controls are driven from their own flops, and
// every hand-over inserts DEAD_CYCLES all-off cycles (break-before-make).
module tgate_mux_arbiter #(
   parameter int unsigned DEAD_CYCLES = 2,  // 1..255
   parameter int unsigned MAX_HOLD    = 8   // 1..255
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic g0_n,
   output logic g0_p,
   output logic g1_n,
   output logic g1_p,
   output logic busy,
   output logic owner
);

   typedef enum logic [1:0] {StIdle, StDead, StGrant0, StGrant1} state_e;

   localparam logic [7:0] DeadLoad = 8'(DEAD_CYCLES - 1);
   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   state_e     st_q, st_d;
   logic       tgt_q, tgt_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic       owner_q, owner_d;
   logic       gnt0_q, gnt1_q;
   logic       g0_n_q, g0_p_q, g1_n_q, g1_p_q;
   logic       busy_q;

   logic [1:0] req_vec;
   logic       cur;        // index of the current owner while granted
   logic       mine_req;
   logic       other_req;

   assign req_vec   = {req1, req0};
   assign cur       = (st_q == StGrant1);
   assign mine_req  = req_vec[cur];
   assign other_req = req_vec[~cur];

   // Next-state logic: arbitration, dead-time countdown and hold-time limit.
   always_comb begin
      st_d    = st_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      owner_d = owner_q;
      unique case (st_q)
         StIdle: begin
            if (req0 || req1) begin
               st_d  = StDead;
               cnt_d = DeadLoad;
               // On a tie the side that did not own last goes first.
               tgt_d = (req0 && req1) ? ~last_q : req1;
            end
         end
         StDead: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (req_vec[tgt_q]) begin
               st_d    = tgt_q ? StGrant1 : StGrant0;
               last_d  = tgt_q;
               owner_d = tgt_q;
               cnt_d   = 8'd0;
            end else begin
               st_d = StIdle;
            end
         end
         StGrant0, StGrant1: begin
            if (!mine_req) begin
               if (other_req) begin
                  st_d  = StDead;
                  tgt_d = ~cur;
                  cnt_d = DeadLoad;
               end else begin
                  st_d  = StIdle;
                  cnt_d = 8'd0;
               end
            end else if (other_req && (cnt_q == HoldLast)) begin
               // Hold limit reached while the other side waits: revoke.
               st_d  = StDead;
               tgt_d = ~cur;
               cnt_d = DeadLoad;
            end else begin
               cnt_d = other_req ? cnt_q + 8'd1 : 8'd0;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   // State and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= StIdle;
         tgt_q   <= 1'b0;
         cnt_q   <= 8'd0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         g0_n_q  <= 1'b0;
         g0_p_q  <= 1'b1;
         g1_n_q  <= 1'b0;
         g1_p_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         gnt0_q  <= (st_d == StGrant0);
         gnt1_q  <= (st_d == StGrant1);
         g0_n_q  <= (st_d == StGrant0);
         g0_p_q  <= (st_d != StGrant0);
         g1_n_q  <= (st_d == StGrant1);
         g1_p_q  <= (st_d != StGrant1);
         busy_q  <= (st_d == StDead);
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign g0_n  = g0_n_q;
   assign g0_p  = g0_p_q;
   assign g1_n  = g1_n_q;
   assign g1_p  = g1_p_q;
   assign busy  = busy_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_tgate_mux_arbiter.sv
// Bench for tgate_mux_arbiter: directed vector table, a long contention
// sequence, then random request traffic against a cycle-level reference model.
module tb_tgate_mux_arbiter;

   localparam int DEAD = 2;
   localparam int HOLD = 8;

   logic clk, rst, req0, req1;
   logic gnt0, gnt1, g0_n, g0_p, g1_n, g1_p, busy, owner;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: granted index (-1 none), dead cycles left,
   // pending target, tie-break memory, owner and hold-cycle count.
   int m_gnt, m_dead, m_tgt, m_last, m_owner, m_hold;

   tgate_mux_arbiter #(.DEAD_CYCLES(DEAD), .MAX_HOLD(HOLD)) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .g0_n  (g0_n),
      .g0_p  (g0_p),
      .g1_n  (g1_n),
      .g1_p  (g1_p),
      .busy  (busy),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic rs, r0, r1;
      logic e_g0, e_g1, e_busy, e_own;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t v(logic rs, logic r0, logic r1,
                              logic g0, logic g1, logic b, logic o);
      vec_t t;
      t.rs = rs; t.r0 = r0; t.r1 = r1;
      t.e_g0 = g0; t.e_g1 = g1; t.e_busy = b; t.e_own = o;
      return t;
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_inv();
      logic ok;
      ok = (g0_p === ~g0_n) && (g1_p === ~g1_n) && !(g0_n && g1_n) &&
           !(gnt0 && gnt1) && (gnt0 === g0_n) && (gnt1 === g1_n);
      chk("invariant", ok, 1'b1);
   endtask

   task automatic model_update(input logic r, input logic a, input logic b);
      int rq[2];
      int x, o;
      rq[0] = a ? 1 : 0;
      rq[1] = b ? 1 : 0;
      if (r) begin
         m_gnt = -1; m_dead = 0; m_tgt = 0; m_last = 1; m_owner = 0; m_hold = 0;
      end else if (m_dead > 0) begin
         if (m_dead > 1) begin
            m_dead--;
         end else begin
            m_dead = 0;
            if (rq[m_tgt] != 0) begin
               m_gnt = m_tgt; m_last = m_tgt; m_owner = m_tgt; m_hold = 0;
            end
         end
      end else if (m_gnt >= 0) begin
         x = m_gnt;
         o = 1 - x;
         if (rq[x] == 0) begin
            m_gnt = -1;
            if (rq[o] != 0) begin
               m_dead = DEAD; m_tgt = o;
            end
         end else if (rq[o] != 0 && m_hold + 1 == HOLD) begin
            m_gnt = -1; m_dead = DEAD; m_tgt = o;
         end else begin
            m_hold = (rq[o] != 0) ? m_hold + 1 : 0;
         end
      end else if (a || b) begin
         m_dead = DEAD;
         m_tgt  = (a && b) ? 1 - m_last : (b ? 1 : 0);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, sample 1 after.
   task automatic step(input logic r, input logic a, input logic b);
      rst = r; req0 = a; req1 = b;
      @(posedge clk);
      model_update(r, a, b);
      #1;
      chk_inv();
   endtask

   initial begin
      logic a, b, r;
      int   p, k;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      m_gnt = -1; m_dead = 0; m_tgt = 0; m_last = 1; m_owner = 0; m_hold = 0;

      //                rs r0 r1  g0 g1 busy own
      // Reset with both requests high.
      tbl[0]  = v(1, 1, 1, 0, 0, 0, 0);
      tbl[1]  = v(1, 1, 1, 0, 0, 0, 0);
      // Single req0: two dead cycles then grant, drop -> idle.
      tbl[2]  = v(0, 1, 0, 0, 0, 1, 0);
      tbl[3]  = v(0, 1, 0, 0, 0, 1, 0);
      tbl[4]  = v(0, 1, 0, 1, 0, 0, 0);
      tbl[5]  = v(0, 0, 0, 0, 0, 0, 0);
      // One-cycle req1 pulse: dead time runs out, back to idle, no grant.
      tbl[6]  = v(0, 0, 1, 0, 0, 1, 0);
      tbl[7]  = v(0, 0, 0, 0, 0, 1, 0);
      tbl[8]  = v(0, 0, 0, 0, 0, 0, 0);
      tbl[9]  = v(0, 0, 0, 0, 0, 0, 0);
      // gnt0 held, req1 rises, req0 drops three cycles later.
      tbl[10] = v(0, 1, 0, 0, 0, 1, 0);
      tbl[11] = v(0, 1, 0, 0, 0, 1, 0);
      tbl[12] = v(0, 1, 0, 1, 0, 0, 0);
      tbl[13] = v(0, 1, 1, 1, 0, 0, 0);
      tbl[14] = v(0, 1, 1, 1, 0, 0, 0);
      tbl[15] = v(0, 1, 1, 1, 0, 0, 0);
      tbl[16] = v(0, 0, 1, 0, 0, 1, 0);
      tbl[17] = v(0, 0, 1, 0, 0, 1, 0);
      tbl[18] = v(0, 0, 1, 0, 1, 0, 1);
      // Reset during GRANT1, then a tie after reset goes to req0.
      tbl[19] = v(0, 0, 1, 0, 1, 0, 1);
      tbl[20] = v(1, 0, 1, 0, 0, 0, 0);
      tbl[21] = v(0, 0, 0, 0, 0, 0, 0);
      tbl[22] = v(0, 1, 1, 0, 0, 1, 0);
      tbl[23] = v(0, 1, 1, 0, 0, 1, 0);
      tbl[24] = v(0, 1, 1, 1, 0, 0, 0);

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].rs, tbl[i].r0, tbl[i].r1);
         chk($sformatf("tbl[%0d] gnt0", i), gnt0, tbl[i].e_g0);
         chk($sformatf("tbl[%0d] gnt1", i), gnt1, tbl[i].e_g1);
         chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl[%0d] owner", i), owner, tbl[i].e_own);
      end

      // Sustained contention from reset: 2 dead, 8 granted, alternating.
      step(1'b1, 1'b1, 1'b1);
      for (int e = 0; e < 45; e++) begin
         step(1'b0, 1'b1, 1'b1);
         if (e < DEAD) begin
            chk($sformatf("contend[%0d] busy", e), busy, 1'b1);
            chk($sformatf("contend[%0d] gnt0", e), gnt0, 1'b0);
            chk($sformatf("contend[%0d] gnt1", e), gnt1, 1'b0);
         end else begin
            p = (e - DEAD) % (HOLD + DEAD);
            k = ((e - DEAD) / (HOLD + DEAD)) % 2;
            chk($sformatf("contend[%0d] busy", e), busy, (p >= HOLD));
            chk($sformatf("contend[%0d] gnt0", e), gnt0, (p < HOLD) && (k == 0));
            chk($sformatf("contend[%0d] gnt1", e), gnt1, (p < HOLD) && (k == 1));
            chk($sformatf("contend[%0d] owner", e), owner, (k == 1));
         end
      end

      // Random traffic: sticky request levels with occasional reset.
      a = 1'b0; b = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(3) == 0) a = ~a;
         if ($urandom_range(3) == 0) b = ~b;
         r = ($urandom_range(99) == 0);
         step(r, a, b);
         chk($sformatf("rand[%0d] gnt0", c), gnt0, (m_gnt == 0));
         chk($sformatf("rand[%0d] gnt1", c), gnt1, (m_gnt == 1));
         chk($sformatf("rand[%0d] busy", c), busy, (m_dead > 0));
         chk($sformatf("rand[%0d] owner", c), owner, (m_owner == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
